alu_vector_player: RTL and testbench

//  Parametrised vector player for ALU bring-up. Holds operand/opcode vectors in internal RAMs, issues them
//  one per cycle to a DUT ALU with a valid strobe, and captures returned results into a result RAM.

---
 rtl/alu_vector_player_pkg.sv | 23 ++
 rtl/alu_vector_player_vec_ram.sv | 37 +++
 rtl/alu_vector_player.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_vector_player.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_vector_player_pkg.sv
// Shared types and defaults for the ALU vector player.
// Optional hardware result checking is enabled by ALU_PLAYER_CHECK_EN.
package alu_player_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 2;
    localparam int RES_W_DEF  = 9;
    localparam int DEPTH_DEF  = 256;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

endpackage

// File: rtl/alu_vector_player_vec_ram.sv
// 1W/1R synchronous RAM used for operand, opcode, result and expected storage.
// Read-before-write on address collision; read register resets to zero.
module vec_ram
    import alu_player_pkg::*;
#(
    parameter int W     = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; returns old data on same-cycle write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/alu_vector_player.sv
// Plays stored operand/opcode vectors into an ALU and captures its results.
// Define ALU_PLAYER_CHECK_EN to add an expected-result RAM and mismatch counting.
module alu_vector_player
    import alu_player_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int RES_W  = RES_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_a,
    input  logic [DATA_W-1:0] load_b,
    input  logic [OP_W-1:0]   load_op,
    input  logic [RES_W-1:0]  load_exp,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              hold,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_valid,
    input  logic [RES_W-1:0]  alu_res,
    input  logic              alu_res_vld,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [RES_W-1:0]  rd_data,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

    state_t              state;
    logic [ADDR_W:0]     run_len;
    logic [ADDR_W:0]     issue_cnt;
    logic [ADDR_W:0]     cap_cnt;
    logic [ADDR_W-1:0]   issue_ptr;
    logic [ADDR_W-1:0]   cap_ptr;
    logic [ADDR_W-1:0]   op_raddr;
    logic [ADDR_W:0]     len_clamped;
    logic                run_go;
    logic                issue_fire;
    logic                cap_fire;
    logic                load_wr;
    logic [DATA_W-1:0]   ram_a;
    logic [DATA_W-1:0]   ram_b;
    logic [OP_W-1:0]     ram_op;

    assign issue_ptr   = issue_cnt[ADDR_W-1:0];
    assign cap_ptr     = cap_cnt[ADDR_W-1:0];
    assign run_go      = (state == IDLE) && start;
    assign issue_fire  = (state == RUN) && !hold;
    assign cap_fire    = alu_res_vld && (state != IDLE);
    assign load_wr     = load_en && (state != RUN) && (state != DRAIN);
    assign len_clamped = (num_vec > DEPTH_CNT) ? DEPTH_CNT : num_vec;

    // Prefetch: the operand RAMs always present the entry issued next cycle.
    always_comb begin
        op_raddr = issue_ptr;
        if (state == IDLE) begin
            op_raddr = '0;
        end else if (issue_fire) begin
            op_raddr = issue_ptr + PTR_ONE;
        end
    end

    vec_ram #(.W(DATA_W), .DEPTH(DEPTH), .AW(ADDR_W)) u_ram_a (
        .clk   (clk),
        .reset (reset),
        .we    (load_wr),
        .waddr (load_addr),
        .wdata (load_a),
        .raddr (op_raddr),
        .rdata (ram_a)
    );

    vec_ram #(.W(DATA_W), .DEPTH(DEPTH), .AW(ADDR_W)) u_ram_b (
        .clk   (clk),
        .reset (reset),
        .we    (load_wr),
        .waddr (load_addr),
        .wdata (load_b),
        .raddr (op_raddr),
        .rdata (ram_b)
    );

    vec_ram #(.W(OP_W), .DEPTH(DEPTH), .AW(ADDR_W)) u_ram_op (
        .clk   (clk),
        .reset (reset),
        .we    (load_wr),
        .waddr (load_addr),
        .wdata (load_op),
        .raddr (op_raddr),
        .rdata (ram_op)
    );

    vec_ram #(.W(RES_W), .DEPTH(DEPTH), .AW(ADDR_W)) u_ram_res (
        .clk   (clk),
        .reset (reset),
        .we    (cap_fire),
        .waddr (cap_ptr),
        .wdata (alu_res),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Run control FSM with registered issue bus, busy and done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            run_len   <= '0;
            issue_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            alu_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
        end else begin
            alu_valid <= issue_fire;
            done      <= 1'b0;
            if (issue_fire) begin
                alu_a  <= ram_a;
                alu_b  <= ram_b;
                alu_op <= ram_op;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        run_len   <= len_clamped;
                        issue_cnt <= '0;
                        if (num_vec == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!hold) begin
                        issue_cnt <= issue_cnt + CNT_ONE;
                        if (issue_cnt + CNT_ONE == run_len) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cap_cnt >= run_len) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture pointer: advances on every accepted result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_cnt <= '0;
        end else if (run_go) begin
            cap_cnt <= '0;
        end else if (cap_fire) begin
            cap_cnt <= cap_cnt + CNT_ONE;
        end
    end

`ifdef ALU_PLAYER_CHECK_EN
    logic [ADDR_W-1:0] exp_raddr;
    logic [RES_W-1:0]  exp_q;

    // Prefetch the expected value for the next capture slot.
    always_comb begin
        exp_raddr = cap_ptr;
        if (state == IDLE) begin
            exp_raddr = '0;
        end else if (cap_fire) begin
            exp_raddr = cap_ptr + PTR_ONE;
        end
    end

    vec_ram #(.W(RES_W), .DEPTH(DEPTH), .AW(ADDR_W)) u_ram_exp (
        .clk   (clk),
        .reset (reset),
        .we    (load_wr),
        .waddr (load_addr),
        .wdata (load_exp),
        .raddr (exp_raddr),
        .rdata (exp_q)
    );

    // Saturating mismatch counter and first-mismatch index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt   <= '0;
            first_err <= '0;
        end else if (run_go) begin
            err_cnt   <= '0;
            first_err <= '0;
        end else if (cap_fire && (alu_res != exp_q)) begin
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
            if (err_cnt == '0) begin
                first_err <= cap_ptr;
            end
        end
    end
`else
    logic unused_exp;
    assign unused_exp = ^load_exp;
    assign err_cnt    = '0;
    assign first_err  = '0;
`endif

endmodule

// File: tb/tb_alu_vector_player.sv
// Self-checking bench for alu_vector_player with a latency-1 registered ALU.
// Build with ALU_PLAYER_CHECK_EN to also exercise hardware result checking.
`timescale 1ns/1ps
module tb_alu_vector_player;

    localparam int DATA_W = 8;
    localparam int OP_W   = 2;
    localparam int RES_W  = 9;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [DATA_W-1:0] load_a = '0;
    logic [DATA_W-1:0] load_b = '0;
    logic [OP_W-1:0]   load_op = '0;
    logic [RES_W-1:0]  load_exp = '0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_vec = '0;
    logic              hold = 1'b0;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic              alu_valid;
    logic [RES_W-1:0]  alu_res;
    logic              alu_res_vld;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [RES_W-1:0]  rd_data;
    logic [ADDR_W:0]   err_cnt;
    logic [ADDR_W-1:0] first_err;

    alu_vector_player #(
        .DATA_W(DATA_W), .OP_W(OP_W), .RES_W(RES_W),
        .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_addr(load_addr),
        .load_a(load_a), .load_b(load_b),
        .load_op(load_op), .load_exp(load_exp),
        .start(start), .num_vec(num_vec), .hold(hold),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_valid(alu_valid),
        .alu_res(alu_res), .alu_res_vld(alu_res_vld),
        .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .err_cnt(err_cnt), .first_err(first_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic [RES_W-1:0]  res;
    } vec_t;

    vec_t tbl [8];

    logic [DATA_W-1:0] ma [DEPTH];
    logic [DATA_W-1:0] mb [DEPTH];
    logic [OP_W-1:0]   mo [DEPTH];
    logic [17:0]       issued [$];
    int                dones;
    int                first_v;
    int                done_c;
    bit                busy_seen;

    function automatic logic [RES_W-1:0] ref_alu(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [OP_W-1:0]   op
    );
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Bench ALU: registered, latency 1.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_res_vld <= 1'b0;
            alu_res     <= '0;
        end else begin
            alu_res_vld <= alu_valid;
            alu_res     <= ref_alu(alu_a, alu_b, alu_op);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int addr, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic [OP_W-1:0] op,
                        input logic [RES_W-1:0] e);
        logic [31:0] av;
        av        = addr;
        load_en   = 1'b1;
        load_addr = av[ADDR_W-1:0];
        load_a    = a;
        load_b    = b;
        load_op   = op;
        load_exp  = e;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        ma[addr] = a;
        mb[addr] = b;
        mo[addr] = op;
    endtask

    task automatic run(input int n, input int hs, input int he);
        logic [31:0] nv;
        issued.delete();
        dones     = 0;
        first_v   = -1;
        done_c    = -1;
        busy_seen = 1'b0;
        nv        = n;
        num_vec   = nv[ADDR_W:0];
        start     = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            hold  = (c >= hs) && (c <= he);
            if (alu_valid) begin
                issued.push_back({alu_a, alu_b, alu_op});
                if (first_v < 0) first_v = c;
            end
            if (busy) busy_seen = 1'b1;
            if (done) begin
                dones++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c >= done_c + 3) break;
        end
        hold = 1'b0;
    endtask

    task automatic verify(input string name, input int n);
        int m;
        int bad;
        m   = (n > DEPTH) ? DEPTH : n;
        bad = 0;
        check({name, " issues"}, issued.size(), m);
        for (int i = 0; i < issued.size() && i < m; i++) begin
            if (issued[i] !== {ma[i], mb[i], mo[i]}) bad++;
        end
        check({name, " order"}, bad, 0);
        check({name, " done_pulses"}, dones, 1);
        for (int i = 0; i < m; i++) begin
            rd_addr = i[ADDR_W-1:0];
            @(posedge clk);
            #1;
            check({name, " rd"}, rd_data, ref_alu(ma[i], mb[i], mo[i]));
        end
    endtask

    initial begin
        bit dseen;

        tbl[0] = '{8'd1,   8'd10,  2'd0, 9'd11};
        tbl[1] = '{8'd2,   8'd10,  2'd0, 9'd12};
        tbl[2] = '{8'd3,   8'd10,  2'd0, 9'd13};
        tbl[3] = '{8'd4,   8'd10,  2'd0, 9'd14};
        tbl[4] = '{8'd255, 8'd255, 2'd0, 9'd510};
        tbl[5] = '{8'd0,   8'd1,   2'd1, 9'h1FF};
        tbl[6] = '{8'hF0,  8'h3C,  2'd2, 9'h030};
        tbl[7] = '{8'hA5,  8'h5A,  2'd3, 9'h0FF};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset valid", alu_valid, 0);
        check("reset alu_a", alu_a, 0);
        check("reset rd_data", rd_data, 0);
        check("reset err_cnt", err_cnt, 0);

        for (int i = 0; i < 8; i++) begin
            load(i, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res);
        end
        for (int i = 0; i < 8; i++) begin
            check("table model", ref_alu(tbl[i].a, tbl[i].b, tbl[i].op),
                  tbl[i].res);
        end

        run(4, 0, -1);
        verify("run4", 4);
        check("run4 first_valid", first_v, 2);
        check("run4 busy_seen", busy_seen, 1);
        check("run4 err_cnt", err_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = i[ADDR_W-1:0];
            @(posedge clk);
            #1;
            check("run4 table res", rd_data, tbl[i].res);
        end

        run(0, 0, -1);
        check("run0 issues", issued.size(), 0);
        check("run0 done_pulses", dones, 1);
        check("run0 done_cycle", done_c, 1);
        check("run0 busy_seen", busy_seen, 0);

        run(8, 3, 5);
        verify("hold8", 8);
        for (int i = 0; i < 8; i++) begin
            rd_addr = i[ADDR_W-1:0];
            @(posedge clk);
            #1;
            check("hold8 table res", rd_data, tbl[i].res);
        end

`ifdef ALU_PLAYER_CHECK_EN
        load(2, tbl[2].a, tbl[2].b, tbl[2].op, tbl[2].res ^ 9'h001);
        run(4, 0, -1);
        check("chk err_cnt", err_cnt, 1);
        check("chk first_err", first_err, 2);
        load(2, tbl[2].a, tbl[2].b, tbl[2].op, tbl[2].res);
        run(4, 0, -1);
        check("chk fixed err_cnt", err_cnt, 0);
`endif

        for (int i = 0; i < DEPTH; i++) begin
            logic [DATA_W-1:0] ra;
            logic [DATA_W-1:0] rb;
            logic [OP_W-1:0]   ro;
            ra = DATA_W'($urandom);
            rb = DATA_W'($urandom);
            ro = OP_W'($urandom_range(0, 3));
            load(i, ra, rb, ro, ref_alu(ra, rb, ro));
        end
        run(300, 0, -1);
        verify("clamp300", 300);
        check("clamp300 err_cnt", err_cnt, 0);

        num_vec = 9'd50;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("midrst busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst valid", alu_valid, 0);
        check("midrst done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        dseen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done || alu_valid) dseen = 1'b1;
        end
        check("midrst quiet", dseen, 0);

        for (int i = 0; i < 4; i++) begin
            load(i, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res);
        end
        run(4, 0, -1);
        verify("after_rst", 4);
        check("after_rst first_valid", first_v, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
